// File: rtl/pipeline_arith_stream.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_arith_stream
// Description : Streaming ADD/SUB/MAX/MIN unit with STAGES register stages,
//               valid/ready handshakes and bubble-collapsing backpressure.
//               Optional macro PIPE_ARITH_SAT_EN selects saturating ADD/SUB.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pipeline_arith_stream #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 5,
    parameter int TAG_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic [1:0]                  in_op,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_result,
    output logic                        out_flag,
    output logic [TAG_W-1:0]            out_tag,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int         c_occ_w  = $clog2(STAGES + 1);
    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_max = 2'b10;

    logic [STAGES-1:0]  valid_q, valid_d;
    logic [STAGES-1:0]  flag_q,  flag_d;
    logic [WIDTH-1:0]   result_q [STAGES];
    logic [WIDTH-1:0]   result_d [STAGES];
    logic [TAG_W-1:0]   tag_q    [STAGES];
    logic [TAG_W-1:0]   tag_d    [STAGES];
    logic [c_occ_w-1:0] occ_q, occ_d;

    logic [STAGES-1:0]  ready_w;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH-1:0]   op_result_w;
    logic               op_flag_w;
    logic               accept_w;
    logic               drain_w;

    // Stage i is ready when any stage from i onward is empty or the consumer
    // takes the head; written flat so no bit of ready_w depends on another.
    always_comb begin
        ready_w = '0;
        for (int i = 0; i < STAGES; i++) begin
            ready_w[i] = out_ready || ((~valid_q >> i) != '0);
        end
    end

    always_comb begin
        sum_w       = {1'b0, in_a} + {1'b0, in_b};
        diff_w      = {1'b0, in_a} - {1'b0, in_b};
        op_result_w = '0;
        op_flag_w   = 1'b0;
        case (in_op)
            c_op_add: begin
                op_flag_w   = sum_w[WIDTH];
`ifdef PIPE_ARITH_SAT_EN
                op_result_w = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
`else
                op_result_w = sum_w[WIDTH-1:0];
`endif
            end
            c_op_sub: begin
                op_flag_w   = diff_w[WIDTH];
`ifdef PIPE_ARITH_SAT_EN
                op_result_w = diff_w[WIDTH] ? {WIDTH{1'b0}} : diff_w[WIDTH-1:0];
`else
                op_result_w = diff_w[WIDTH-1:0];
`endif
            end
            c_op_max: op_result_w = (in_a > in_b) ? in_a : in_b;
            default:  op_result_w = (in_a < in_b) ? in_a : in_b;
        endcase
    end

    assign accept_w = in_valid && ready_w[0];
    assign drain_w  = valid_q[STAGES-1] && out_ready;

    // Payload only moves with a valid transaction, so the head registers keep
    // their last value while the output is idle.
    always_comb begin
        valid_d  = valid_q;
        flag_d   = flag_q;
        result_d = result_q;
        tag_d    = tag_q;
        if (ready_w[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                result_d[0] = op_result_w;
                flag_d[0]   = op_flag_w;
                tag_d[0]    = in_tag;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (ready_w[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    result_d[i] = result_q[i-1];
                    flag_d[i]   = flag_q[i-1];
                    tag_d[i]    = tag_q[i-1];
                end
            end
        end
        occ_d = occ_q;
        if (accept_w && !drain_w) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept_w && drain_w) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            flag_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                result_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            flag_q  <= flag_d;
            occ_q   <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                result_q[i] <= result_d[i];
                tag_q[i]    <= tag_d[i];
            end
        end
    end

    assign in_ready   = ready_w[0];
    assign out_valid  = valid_q[STAGES-1];
    assign out_result = result_q[STAGES-1];
    assign out_flag   = flag_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign occupancy  = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_arith_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_arith_stream
// Description : Directed self-checking bench for pipeline_arith_stream
//               (WIDTH=8, STAGES=5, TAG_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_arith_stream;

    localparam int         WIDTH  = 8;
    localparam int         STAGES = 5;
    localparam int         TAG_W  = 4;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MAX = 2'b10;
    localparam logic [1:0] OP_MIN = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       occupancy;

    int n_vec = 0;
    int n_err = 0;
    int acc;

    int         s_a   [5] = '{10, 20, 30, 200, 5};
    int         s_b   [5] = '{15, 5, 40, 100, 10};
    logic [1:0] s_op  [5] = '{OP_ADD, OP_SUB, OP_MAX, OP_ADD, OP_SUB};
    int         s_flg [5] = '{0, 0, 0, 1, 1};
`ifdef PIPE_ARITH_SAT_EN
    int         s_res [5] = '{25, 15, 40, 255, 0};
    int         sub_3_9   = 0;
`else
    int         s_res [5] = '{25, 15, 40, 44, 251};
    int         sub_3_9   = 250;
`endif

    always #5 clk = ~clk;

    pipeline_arith_stream #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .out_tag    (out_tag),
        .occupancy  (occupancy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b,
                         input logic [1:0] op, input int tag);
        in_valid = v;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_op    = op;
        in_tag   = 4'(tag);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with a valid transaction offered
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1, 2, OP_ADD, 7);
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        rst = 1'b1;
        drive(1'b0, 0, 0, OP_ADD, 0);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        cyc();

        // Single ADD: presented in cycle 0, visible only in cycle 5
        drive(1'b1, 10, 15, OP_ADD, 3);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            drive(1'b0, 0, 0, OP_ADD, 0);
            check("single_valid", 32'(out_valid), (c == 5) ? 1 : 0);
            if (c == 5) begin
                check("single_result", 32'(out_result), 25);
                check("single_flag", 32'(out_flag), 0);
                check("single_tag", 32'(out_tag), 3);
            end
        end
        check("single_hold", 32'(out_result), 25);

        // Five back-to-back ops, results in cycles 5..9
        drive(1'b1, s_a[0], s_b[0], s_op[0], 0);
        for (int e = 1; e <= 10; e++) begin
            cyc();
            if (e <= 4) drive(1'b1, s_a[e], s_b[e], s_op[e], e);
            else        drive(1'b0, 0, 0, OP_ADD, 0);
            if (e >= 5 && e <= 9) begin
                check("stream_valid", 32'(out_valid), 1);
                check("stream_result", 32'(out_result), 32'(s_res[e-5]));
                check("stream_flag", 32'(out_flag), 32'(s_flg[e-5]));
                check("stream_tag", 32'(out_tag), 32'(e - 5));
            end else begin
                check("stream_idle", 32'(out_valid), 0);
            end
            if (e == 5) check("stream_occ", 32'(occupancy), 5);
        end

        // Backpressure: only STAGES transactions fit
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, acc, 1, OP_ADD, acc);
            #1;
            if (in_ready) acc++;
            cyc();
        end
        check("bp_accepted", 32'(acc), 5);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_occupancy", 32'(occupancy), 5);
        drive(1'b0, 0, 0, OP_ADD, 0);
        out_ready = 1'b1;
        #1;
        check("bp_pass_ready", 32'(in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", 32'(out_valid), 1);
            check("bp_drain_tag", 32'(out_tag), 32'(k));
            check("bp_drain_result", 32'(out_result), 32'(k + 1));
            cyc();
        end
        check("bp_empty_valid", 32'(out_valid), 0);
        check("bp_empty_occ", 32'(occupancy), 0);

        // Bubble collapse: two ops three cycles apart under a stall
        out_ready = 1'b0;
        drive(1'b1, 7, 3, OP_MIN, 1);
        cyc();
        drive(1'b0, 0, 0, OP_ADD, 0);
        cyc();
        check("bub_ready_a", 32'(in_ready), 1);
        cyc();
        check("bub_ready_b", 32'(in_ready), 1);
        drive(1'b1, 3, 9, OP_SUB, 2);
        cyc();
        drive(1'b0, 0, 0, OP_ADD, 0);
        cyc();
        cyc();
        cyc();
        check("bub_head_valid", 32'(out_valid), 1);
        check("bub_head_tag", 32'(out_tag), 1);
        check("bub_occ2", 32'(occupancy), 2);
        check("bub_ready_c", 32'(in_ready), 1);
        for (int k = 3; k <= 5; k++) begin
            drive(1'b1, k, k, OP_ADD, k);
            #1;
            check("bub_fill_ready", 32'(in_ready), 1);
            cyc();
        end
        drive(1'b1, 6, 6, OP_ADD, 6);
        #1;
        check("bub_full_ready", 32'(in_ready), 0);
        check("bub_full_occ", 32'(occupancy), 5);
        drive(1'b0, 0, 0, OP_ADD, 0);
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bub_drain_valid", 32'(out_valid), 1);
            check("bub_drain_tag", 32'(out_tag), 32'(k + 1));
            if (k == 0) check("bub_min_result", 32'(out_result), 3);
            if (k == 1) begin
                check("bub_sub_result", 32'(out_result), 32'(sub_3_9));
                check("bub_sub_flag", 32'(out_flag), 1);
            end
            cyc();
        end
        check("bub_empty_valid", 32'(out_valid), 0);

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 40 + k, 1, OP_ADD, 8 + k);
            cyc();
        end
        drive(1'b0, 0, 0, OP_ADD, 0);
        check("mid_occ_pre", 32'(occupancy), 3);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_result", 32'(out_result), 0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            check("mid_no_stale", 32'(out_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_arith_stream.md
Name: pipeline_arith_stream

Overview:
Parametrised successor to the fixed 8-bit, 5-stage adder pipeline. Streaming arithmetic unit with STAGES register stages and per-operation opcode select. A pass-through tag lets the bench check ordering. Valid/ready handshakes on both ends, with bubble-collapsing backpressure. Sits between operand producers and result consumers in the arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
STAGES, 5, number of pipeline register stages, i.e. latency (>=2)
TAG_W, 4, width of pass-through transaction tag (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  unit can accept this cycle
in_a  in  WIDTH  operand A (unsigned)
in_b  in  WIDTH  operand B (unsigned)
in_op  in  2  00 ADD, 01 SUB (a-b), 10 MAX, 11 MIN
in_tag  in  TAG_W  transaction tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  result
out_flag  out  1  ADD carry-out / SUB borrow; 0 for MAX/MIN
out_tag  out  TAG_W  tag of the result
occupancy  out  $clog2(STAGES+1)  transactions currently in flight

Behaviour:
- Reset: rst=0 sampled on a clk edge clears every stage valid bit, occupancy, out_result, out_flag and out_tag to 0. out_valid=0. Reset overrides any handshake in the same cycle, and in-flight data is discarded.
- Accept: transaction accepted on an edge where in_valid && in_ready.
- Stage 0 registering: the op is computed combinationally from the inputs and registered into stage 0 together with flag and tag.
- Later stages: stages 1..STAGES-1 carry {valid, result, flag, tag} unchanged.
- Outputs: driven directly from stage STAGES-1 registers.
- Latency: a transaction accepted on edge k appears on the outputs after edge k+STAGES-1 when there is no backpressure. With STAGES=5, inputs presented in cycle 0 give out_valid in cycle 5.
- Throughput: one transaction per cycle when out_ready=1.
- Ready chain: ready_last = out_ready; ready_i = !valid_i || ready_(i+1); in_ready = ready_0. This is a combinational chain, with no register in the ready path.
- Bubble collapse: stage i loads from stage i-1 whenever ready_i. Empty stages are filled while downstream is stalled, so all STAGES slots are usable under backpressure.
- Stage clearing: a stage that passes its data on and receives nothing new clears its valid bit.
- Data in empty stages: don't-care internally, but out_result/out_flag/out_tag hold their last value while out_valid=0.
- Arithmetic, ADD: a+b mod 2^WIDTH; flag = carry-out.
- Arithmetic, SUB: a-b mod 2^WIDTH; flag = (a<b).
- Arithmetic, MAX/MIN: unsigned compare; flag = 0.
- occupancy: registered counter. +1 on accept, -1 on output handshake (out_valid && out_ready), unchanged when both occur in the same cycle. It equals the count of set stage valid bits.
- Full condition: occupancy==STAGES with out_ready=0 forces in_ready=0. Pass-through still happens when full: if out_ready=1, in_ready=1 in the same cycle.
- Empty condition: out_ready is ignored when out_valid=0.
- Ordering: results leave in acceptance order. No loss, no duplication.

Optional Feature:
Macro PIPE_ARITH_SAT_EN.
- Defined: ADD saturates to 2^WIDTH-1 on carry; SUB saturates to 0 on borrow. out_flag still reports the carry/borrow.
- Undefined: ADD and SUB wrap modulo 2^WIDTH.
- MAX/MIN are unaffected either way.

Test Plan:
1. Reset: rst=0 for 2 edges with in_valid=1 -> out_valid=0, out_result=0, occupancy=0; after release in_ready=1.
2. Single op (WIDTH=8, STAGES=5): a=10, b=15, ADD, tag=3 presented in cycle 0, out_ready=1 -> out_valid=1 only in cycle 5, result=25, flag=0, tag=3.
3. Stream of five ops on consecutive cycles with out_ready=1:
   - ops: 10+15, 20-5, max(30,40), 200+100, 5-10; tags 0..4.
   - results in cycles 5..9: 25/0, 15/0, 40/0, 44/1, 251/1 (flag shown after /).
   - with PIPE_ARITH_SAT_EN: last two results are 255/1 and 0/1.
4. Backpressure: out_ready=0, continuous in_valid -> exactly 5 accepted, in_ready=0, occupancy=5. Then out_ready=1 -> 5 results drained in tag order, and in_ready=1 in that same cycle.
5. Bubble collapse: 2 ops accepted 3 cycles apart, out_ready=0 -> both reach stages 4/3, in_ready stays 1, occupancy=2. 3 further accepts bring occupancy=5 and in_ready=0.
6. Reset mid-flight: 3 in flight, rst=0 for one edge -> out_valid=0 and occupancy=0 next cycle. No stale result appears within the following 10 cycles.
